// File: rtl/int_add_chk_pkg.sv
// Shared types and helpers for the integer-adder result checker.
package int_add_chk_pkg;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CHECK,
    DONE
  } chk_state_e;

  // Width used by the generic saturating adder; callers zero-extend into it.
  localparam int unsigned SAT_W = 64;

  // A log entry packs {a, b, dut_c}, so it is three operand widths wide.
  function automatic int unsigned log_entry_width(input int unsigned op_w);
    return 3 * op_w;
  endfunction

  // Returns min(x + y, max_val); the extra carry bit keeps the compare exact.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] x,
                                               input logic [SAT_W-1:0] y,
                                               input logic [SAT_W-1:0] max_val);
    logic [SAT_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/chk_log_fifo.sv
// Mismatch log: synchronous FIFO with a registered read port. A push into a
// full FIFO is still accepted when a pop frees a slot in the same cycle.
module chk_log_fifo
  import int_add_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_drop,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;

  logic [AW:0] w_count;
  logic        w_full;
  logic        w_pop_ok;
  logic        w_push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == FULL_CNT);
  assign o_empty   = (w_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;

  // Storage write; when full with a pop, this overwrites the slot being read,
  // and the read below still sees the old contents.
  // NOTE: the storage array has no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointer advance and registered read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
      r_rd_valid <= w_pop_ok;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/int_add_result_checker.sv
// Checks an integer adder's output against an exact reference, keeps error
// statistics and logs mismatching samples for later draining.
module int_add_result_checker
  import int_add_chk_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH  = 32,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned LOG_DEPTH    = 16,
  parameter int unsigned ACC_BITWIDTH = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             num_samples,
  input  logic                    in_valid,
  input  logic [OP_BITWIDTH-1:0]  a,
  input  logic [OP_BITWIDTH-1:0]  b,
  input  logic [OP_BITWIDTH-1:0]  dut_c,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             sample_cnt,
  output logic [15:0]             err_cnt,
  output logic [OP_BITWIDTH:0]    max_abs_err,
  output logic [ACC_BITWIDTH-1:0] sum_abs_err,
  output logic                    log_ovf,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [OP_BITWIDTH-1:0]  rd_a,
  output logic [OP_BITWIDTH-1:0]  rd_b,
  output logic [OP_BITWIDTH-1:0]  rd_c,
  output logic                    log_empty
);

  localparam int unsigned ENTRY_W = log_entry_width(OP_BITWIDTH);
  localparam int unsigned DW      = OP_BITWIDTH + 1;
  localparam logic [ACC_BITWIDTH-1:0] ACC_MAX = '1;

  // Operand delay line matching the adder latency.
  logic                   r_dv [LATENCY];
  logic [OP_BITWIDTH-1:0] r_da [LATENCY];
  logic [OP_BITWIDTH-1:0] r_db [LATENCY];

  chk_state_e r_state, w_next_state;
  logic       r_done;

  logic [15:0]             r_num;
  logic [15:0]             r_sample_cnt;
  logic [15:0]             r_err_cnt;
  logic [DW-1:0]           r_max_abs_err;
  logic [ACC_BITWIDTH-1:0] r_sum_abs_err;
  logic                    r_log_ovf;

  logic                   w_run_start;
  logic                   w_cmp;
  logic                   w_mismatch;
  logic [15:0]            w_cnt_next;
  logic                   w_last;
  logic [OP_BITWIDTH-1:0] w_expected;
  logic [DW-1:0]          w_diff;
  logic [DW-1:0]          w_abs_err;
  logic                   w_log_drop;
  logic [ENTRY_W-1:0]     w_rd_data;

  // Shift operands through the delay line in every state.
  // NOTE: sequential state uses non-blocking assignments so each stage takes
  // its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_dv[i] <= 1'b0;
        r_da[i] <= '0;
        r_db[i] <= '0;
      end
    end else begin
      r_dv[0] <= in_valid;
      r_da[0] <= a;
      r_db[0] <= b;
      for (int i = 1; i < LATENCY; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_da[i] <= r_da[i-1];
        r_db[i] <= r_db[i-1];
      end
    end
  end

  // Reference sum wraps like the adder; the difference is taken one bit wider.
  assign w_expected = r_da[LATENCY-1] + r_db[LATENCY-1];
  assign w_diff     = {1'b0, dut_c} - {1'b0, w_expected};
  assign w_abs_err  = w_diff[DW-1] ? (-w_diff) : w_diff;

  assign w_run_start = start && (r_state == IDLE || r_state == DONE);
  assign w_cmp       = r_dv[LATENCY-1] &&
                       ((r_state == ARMED && r_num != '0) || r_state == CHECK);
  assign w_mismatch  = w_cmp && (dut_c != w_expected);
  assign w_cnt_next  = r_sample_cnt + 16'd1;
  assign w_last      = w_cmp && (w_cnt_next == r_num);

  // FSM state register; done is registered on entry into DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == DONE) && (r_state != DONE);
    end
  end

  // FSM next-state logic.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: if (w_run_start) w_next_state = ARMED;
      ARMED: begin
        if (r_num == '0)  w_next_state = DONE;
        else if (w_last)  w_next_state = DONE;
        else if (w_cmp)   w_next_state = CHECK;
      end
      CHECK:   if (w_last) w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (r_state == ARMED) || (r_state == CHECK);
    done = r_done;
  end

  // Statistics: cleared on run start, updated on every compare.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_num         <= '0;
      r_sample_cnt  <= '0;
      r_err_cnt     <= '0;
      r_max_abs_err <= '0;
      r_sum_abs_err <= '0;
      r_log_ovf     <= 1'b0;
    end else if (w_run_start) begin
      r_num         <= num_samples;
      r_sample_cnt  <= '0;
      r_err_cnt     <= '0;
      r_max_abs_err <= '0;
      r_sum_abs_err <= '0;
      r_log_ovf     <= 1'b0;
    end else begin
      if (w_cmp) r_sample_cnt <= w_cnt_next;
      if (w_mismatch) begin
        r_err_cnt <= 16'(sat_add(SAT_W'(r_err_cnt), SAT_W'(1), SAT_W'(16'hFFFF)));
        if (w_abs_err > r_max_abs_err) r_max_abs_err <= w_abs_err;
        r_sum_abs_err <= ACC_BITWIDTH'(sat_add(SAT_W'(r_sum_abs_err),
                                               SAT_W'(w_abs_err),
                                               SAT_W'(ACC_MAX)));
      end
      if (w_log_drop) r_log_ovf <= 1'b1;
    end
  end

  chk_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_run_start),
    .i_push     (w_mismatch),
    .i_data     ({r_da[LATENCY-1], r_db[LATENCY-1], dut_c}),
    .i_pop      (rd_en),
    .o_drop     (w_log_drop),
    .o_rd_valid (rd_valid),
    .o_rd_data  (w_rd_data),
    .o_empty    (log_empty)
  );

  assign sample_cnt  = r_sample_cnt;
  assign err_cnt     = r_err_cnt;
  assign max_abs_err = r_max_abs_err;
  assign sum_abs_err = r_sum_abs_err;
  assign log_ovf     = r_log_ovf;
  assign rd_a        = w_rd_data[3*OP_BITWIDTH-1:2*OP_BITWIDTH];
  assign rd_b        = w_rd_data[2*OP_BITWIDTH-1:OP_BITWIDTH];
  assign rd_c        = w_rd_data[OP_BITWIDTH-1:0];

endmodule

// File: doc/int_add_result_checker.md
# int_add_result_checker

Hardware result checker that sits on the output side of the integer adder under test (`unconfig_int_add`, exact or approximate). It receives the operand stream driven into the adder, aligns it with the adder's registered latency and recomputes the exact sum. It compares that sum against the adder's `c` output and keeps error statistics. Mismatching samples are buffered in a small log FIFO that a host or bench drains through a valid/read handshake, replacing file-based post-processing.

## Interface
Parameters:
- `OP_BITWIDTH`, 32: operand and result width.
- `LATENCY`, 1: adder latency in cycles from operand to `c`. Range is 1..8.
- `LOG_DEPTH`, 16: mismatch log entries. Must be a power of two, at least 2.
- `ACC_BITWIDTH`, 48: width of the absolute-error sum accumulator.

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-low.
- `start`, in, 1: pulse that begins a run. Ignored unless the FSM is in IDLE or DONE.
- `num_samples`, in, 16: samples to check in the run. It is latched on `start`.
- `in_valid`, in, 1: `a` and `b` are being presented to the adder this cycle.
- `a`, in, OP_BITWIDTH: operand a, as driven to the adder.
- `b`, in, OP_BITWIDTH: operand b, as driven to the adder.
- `dut_c`, in, OP_BITWIDTH: the adder's `c` output.
- `busy`, out, 1: high in the ARMED and CHECK states.
- `done`, out, 1: one-cycle pulse when the run completes.
- `sample_cnt`, out, 16: number of compared samples.
- `err_cnt`, out, 16: number of mismatches. Saturates at 0xFFFF.
- `max_abs_err`, out, OP_BITWIDTH+1: largest \|dut_c − expected\|.
- `sum_abs_err`, out, ACC_BITWIDTH: sum of \|dut_c − expected\|. Saturates at its maximum value.
- `log_ovf`, out, 1: sticky. Set when a mismatch was dropped because the log was full.
- `rd_en`, in, 1: pop request for the log.
- `rd_valid`, out, 1: `rd_a`, `rd_b` and `rd_c` are valid this cycle.
- `rd_a`, out, OP_BITWIDTH: logged operand a.
- `rd_b`, out, OP_BITWIDTH: logged operand b.
- `rd_c`, out, OP_BITWIDTH: logged adder output.
- `log_empty`, out, 1: the log holds no entries.

## Operation
- States:
  - IDLE: waiting for a run.
  - ARMED: counters cleared, waiting for the first aligned sample.
  - CHECK: comparing samples.
  - DONE: run complete.
- Transitions:
  - IDLE or DONE → ARMED on `start`. This clears all statistics, `log_ovf` and the log, and latches `num_samples`.
  - ARMED → CHECK on the first aligned valid sample, which is also compared that cycle.
  - CHECK → DONE when `sample_cnt` reaches `num_samples`. `done` pulses on this transition.
  - A `start` with `num_samples`=0 goes ARMED → DONE on the next cycle, with a `done` pulse.
- Alignment: `in_valid`, `a` and `b` pass through a LATENCY-stage shift register. The aligned sample is compared against `dut_c` in the cycle its delayed valid is high. The delay line runs in every state. Operand beats outside ARMED/CHECK are not compared.
- Arithmetic:
  - expected = (a + b) mod 2^OP_BITWIDTH, so the wrap-around is part of the reference.
  - diff = dut_c − expected, computed as an OP_BITWIDTH+1-bit signed value with both operands zero-extended.
  - abs_err = \|diff\|.
- Mismatch is defined as dut_c ≠ expected. Each mismatch:
  - increments `err_cnt` (saturating),
  - updates `max_abs_err` if larger,
  - adds abs_err to `sum_abs_err` (saturating),
  - pushes {a, b, dut_c} to the log.
- Log push:
  - A push is accepted when the occupancy is below LOG_DEPTH, or when a pop happens in the same cycle.
  - Otherwise the entry is dropped and `log_ovf` is set.
- Log read:
  - `rd_en` while the log is not empty pops the oldest entry.
  - The popped data appears with `rd_valid`=1 on the next cycle.
  - `rd_en` while the log is empty is ignored, and `rd_valid` is 0 on the next cycle.
  - The log can be drained in any state and persists until the next `start`.
- Reset while in any state:
  - returns to IDLE,
  - clears the delay line, all counters, `log_ovf`, the log pointers and `rd_valid`.
  - A run interrupted by reset does not produce a `done` pulse.

## Timing
- Reset values: all outputs are 0, except `log_empty`=1.
- An operand beat at cycle t is compared at t+LATENCY.
- Statistics outputs are registered. They reflect a compare one cycle after it occurs.
- `done` asserts in the cycle after the final compare, together with the final statistics values.
- Log latency: a mismatch compared at cycle t is poppable from t+1. `rd_en` at cycle t gives data at t+1.
- Throughput: one sample per cycle, and one log push plus one pop per cycle, sustained.

## Structure
- Package `int_add_chk_pkg`:
  - FSM state enum: IDLE, ARMED, CHECK, DONE.
  - A log-entry struct parameterized by OP_BITWIDTH, or a localparam for the packed entry width.
  - A saturating-add function.
- Sub-module `chk_log_fifo`: synchronous FIFO with a registered read port, simultaneous push and pop, and push-when-full-with-pop.
- The delay line, arithmetic and FSM stay in the top module.

## Test plan
- **Exact adder, LATENCY=1, 500 random pairs** with the adder model exact → `sample_cnt`=500, `err_cnt`=0, `log_empty`=1, `done` pulses once.
- **Wrap-around**: a=0xFFFFFFFF, b=0x00000001 with dut_c=0 → no error. The same pair with dut_c=0x100 → `err_cnt`=1, `max_abs_err`=0x100, and the log pops {0xFFFFFFFF, 0x1, 0x100}.
- **Injected errors**: dut_c = expected−3 on samples 10 and 20, and expected+7 on sample 30 → `err_cnt`=3, `max_abs_err`=7, `sum_abs_err`=13, with three log entries in order.
- **Log overflow**: LOG_DEPTH=16, 20 consecutive mismatches, no reads → 16 entries retained (the first 16), `log_ovf`=1, `err_cnt`=20.
- **Simultaneous push and pop while full**: `rd_en` held during a mismatch with 16 entries stored → the push is accepted, `log_ovf` stays 0, the occupancy stays 16.
- **Reset mid-run**: `rst`=0 for one cycle after 50 of 100 samples → the FSM returns to IDLE, all outputs return to reset values, and there is no `done` pulse. A new `start` then completes normally.
